bcd_display_scanner: RTL and testbench

Downstream consumer of the binary-to-BCD converter output. Captures a two-digit BCD value on a load strobe into a shadow register and scans it onto a time-multiplexed, common-anode, two-digit 7-segment display. A new value is transferred to the displayed register only at a full scan boundary, so a digit pair is never shown half-old, half-new. Adds leading-zero blanking, an invalid-digit flag and an active-low display enable matching the converters' `enable_n` style.

---
 rtl/bcd_display_scanner_pkg.sv | 27 ++
 rtl/bcd_display_scanner_seg7_decode.sv | 27 ++
 rtl/bcd_display_scanner.sv | 95 +++++++++
 tb/tb_bcd_display_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and helpers for the two-digit BCD display scanner.
package bcd_display_pkg;

  // Active-low glyphs, bit order g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } digit_sel_e;

  function automatic int div_width(input int scan_div);
    return $clog2(scan_div);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7_decode.sv
// Single BCD digit to active-low 7-segment glyph; non-decimal codes show a dash.
module seg7_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  // Glyph lookup
  always_comb begin
    seg_n = SEG_DASH;
    case (digit)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed common-anode display scanner with shadow/active
// double buffering so a new value only appears at a full scan boundary.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       enable_n,
  input  logic       load,
  input  logic [7:0] bcd_in,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       pending,
  output logic       err
);

  localparam int DIV_W = div_width(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] divider_q, divider_d;
  digit_sel_e       digit_q, digit_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       active_q, active_d;
  logic             pending_q, pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  logic             term_cnt;
  logic             transfer;
  logic [3:0]       mux_digit;
  logic [6:0]       dec_seg;
  logic             blank_tens;

  seg7_decode u_decode (
    .digit (mux_digit),
    .seg_n (dec_seg)
  );

  // Next-state: divider/digit scan, load capture, boundary transfer, output image
  always_comb begin
    term_cnt   = (divider_q == DIV_LAST);
    divider_d  = term_cnt ? '0 : divider_q + 1'b1;
    digit_d    = digit_q;
    if (term_cnt) digit_d = (digit_q == ONES) ? TENS : ONES;

    // Transfer reads the pre-edge shadow, so a same-cycle load stays pending
    transfer   = term_cnt && (digit_q == TENS) && pending_q;
    active_d   = transfer ? shadow_q : active_q;
    shadow_d   = load ? bcd_in : shadow_q;
    pending_d  = pending_q;
    if (transfer) pending_d = 1'b0;
    if (load)     pending_d = 1'b1;

    mux_digit  = (digit_q == TENS) ? active_q[7:4] : active_q[3:0];
    blank_tens = (BLANK_LZ != 0) && (digit_q == TENS) && (active_q[7:4] == 4'd0);

    seg_d = dec_seg;
    an_d  = (digit_q == TENS) ? 2'b01 : 2'b10;
    if (blank_tens) seg_d = SEG_BLANK;
    if (enable_n) begin
      seg_d = SEG_BLANK;
      an_d  = 2'b11;
    end
  end

  // State and output registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      divider_q <= '0;
      digit_q   <= ONES;
      shadow_q  <= 8'h00;
      active_q  <= 8'h00;
      pending_q <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= 2'b11;
    end else begin
      divider_q <= divider_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg_n   = seg_q;
  assign an_n    = an_q;
  assign pending = pending_q;
  assign err     = (active_q[7:4] > 4'd9) || (active_q[3:0] > 4'd9);

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with a cycle-level reference model.
module tb_bcd_display_scanner;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       enable_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] bcd_in = 8'h00;

  logic [6:0] seg1, seg0;
  logic [1:0] an1, an0;
  logic       pend1, pend0, err1, err0;

  int vectors = 0;
  int miscompares = 0;

  bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1)) u_lz (
    .clk(clk), .clear_n(clear_n), .enable_n(enable_n), .load(load), .bcd_in(bcd_in),
    .seg_n(seg1), .an_n(an1), .pending(pend1), .err(err1)
  );

  bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_LZ(0)) u_nolz (
    .clk(clk), .clear_n(clear_n), .enable_n(enable_n), .load(load), .bcd_in(bcd_in),
    .seg_n(seg0), .an_n(an0), .pending(pend0), .err(err0)
  );

  always #5 clk = ~clk;

  // Reference model: scan position as a plain cycle count since reset
  int         t = 0;
  int         m_shadow = 0;
  int         m_active = 0;
  bit         m_pend = 0;
  bit         m_tens;
  int         m_shown;
  logic [6:0] e_seg1 = 7'h7F;
  logic [6:0] e_seg0 = 7'h7F;
  logic [1:0] e_an = 2'b11;

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 9) return 7'h3F;
    return tbl[d];
  endfunction

  always @(posedge clk) begin
    if (!clear_n) begin
      t = 0; m_shadow = 0; m_active = 0; m_pend = 0;
      e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_an = 2'b11;
    end else begin
      m_tens  = ((t / SD) % 2) == 1;
      m_shown = m_tens ? (m_active / 16) : (m_active % 16);
      if (enable_n) begin
        e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_an = 2'b11;
      end else begin
        e_an   = m_tens ? 2'b01 : 2'b10;
        e_seg0 = glyph(m_shown);
        e_seg1 = (m_tens && m_shown == 0) ? 7'h7F : glyph(m_shown);
      end
      if (m_tens && (t % SD) == SD - 1 && m_pend) begin
        m_active = m_shadow;
        m_pend   = 0;
      end
      if (load) begin
        m_shadow = bcd_in;
        m_pend   = 1;
      end
      t++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("seg_lz",  {1'b0, seg1}, {1'b0, e_seg1});
    chk("seg_nolz", {1'b0, seg0}, {1'b0, e_seg0});
    chk("an_lz",   {6'd0, an1}, {6'd0, e_an});
    chk("an_nolz", {6'd0, an0}, {6'd0, e_an});
    chk("pending", {7'd0, pend1}, {7'd0, m_pend});
    chk("pending_nolz", {7'd0, pend0}, {7'd0, m_pend});
    chk("err", {7'd0, err1},
        {7'd0, ((m_active / 16) > 9) || ((m_active % 16) > 9)});
  end

  task automatic wait_show(input string name, input logic [1:0] an, input logic [6:0] seg);
    bit ok = 0;
    for (int n = 0; n < 6 * SD && !ok; n++) begin
      @(negedge clk);
      if (an1 === an && seg1 === seg) ok = 1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: an_n=%b seg_n=%h, expected an_n=%b seg_n=%h within %0d cycles",
               name, an1, seg1, an, seg, 6 * SD);
    end
  endtask

  task automatic pulse_load(input logic [7:0] v);
    bcd_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    clear_n = 1'b0; enable_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {1'b0, seg1}, 8'h7F);
    chk("rst_an", {6'd0, an1}, 8'h03);
    chk("rst_pending", {7'd0, pend1}, 8'h00);
    clear_n = 1'b1;
    @(negedge clk);
    chk("first_an", {6'd0, an1}, 8'h02);
    chk("first_seg", {1'b0, seg1}, 8'h40);

    // Basic load
    pulse_load(8'h42);
    chk("load42_pending", {7'd0, pend1}, 8'h01);
    wait_show("show42_ones", 2'b10, 7'h24);
    chk("load42_done", {7'd0, pend1}, 8'h00);
    wait_show("show42_tens", 2'b01, 7'h19);

    // Leading-zero blanking
    pulse_load(8'h07);
    wait_show("show07_ones", 2'b10, 7'h78);
    wait_show("show07_tens_blank", 2'b01, 7'h7F);
    chk("show07_tens_nolz", {1'b0, seg0}, 8'h40);
    chk("show07_tens_an", {6'd0, an1}, 8'h01);

    // Invalid digit
    pulse_load(8'h3C);
    wait_show("show3c_ones", 2'b10, 7'h3F);
    chk("err_set", {7'd0, err1}, 8'h01);
    pulse_load(8'h15);
    wait_show("show15_ones", 2'b10, 7'h12);
    chk("err_clear", {7'd0, err1}, 8'h00);
    wait_show("show15_tens", 2'b01, 7'h79);

    // Load collisions
    for (int i = 0; i < 2 * SD && (t % (2 * SD)) != 0; i++) @(negedge clk);
    pulse_load(8'h11);
    pulse_load(8'h22);
    for (int i = 0; i < 2 * SD && (t % (2 * SD)) != 2 * SD - 1; i++) @(negedge clk);
    pulse_load(8'h33);
    chk("collide_pending", {7'd0, pend1}, 8'h01);
    wait_show("show22_ones", 2'b10, 7'h24);
    chk("collide_still_pending", {7'd0, pend1}, 8'h01);
    wait_show("show33_ones", 2'b10, 7'h30);
    chk("show33_done", {7'd0, pend1}, 8'h00);
    wait_show("show33_tens", 2'b01, 7'h30);

    // Enable with a transfer in flight
    pulse_load(8'h44);
    enable_n = 1'b1;
    @(negedge clk);
    chk("dis_an", {6'd0, an1}, 8'h03);
    chk("dis_seg", {1'b0, seg1}, 8'h7F);
    for (int i = 0; i < 3 * SD && pend1 !== 1'b0; i++) @(negedge clk);
    chk("dis_transfer", {7'd0, pend1}, 8'h00);
    enable_n = 1'b0;
    wait_show("show44_tens", 2'b01, 7'h19);
    wait_show("show44_ones", 2'b10, 7'h19);

    // Mid-slot clear drops a pending load
    for (int i = 0; i < SD && (t % SD) != 1; i++) @(negedge clk);
    pulse_load(8'h55);
    clear_n = 1'b0;
    @(negedge clk);
    chk("midrst_seg", {1'b0, seg1}, 8'h7F);
    chk("midrst_an", {6'd0, an1}, 8'h03);
    chk("midrst_pending", {7'd0, pend1}, 8'h00);
    chk("midrst_err", {7'd0, err1}, 8'h00);
    clear_n = 1'b1;
    @(negedge clk);
    chk("midrst_first_an", {6'd0, an1}, 8'h02);
    chk("midrst_first_seg", {1'b0, seg1}, 8'h40);
    repeat (2 * SD + 2) @(negedge clk);
    chk("midrst_no_pending", {7'd0, pend1}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
